// File: rtl/camera_frame_capture.sv
// Captures one camera frame of RGB bytes into the frame RAM.
// Hands the frame to the colour stage and holds it until that stage pulses done.
//
// Ports:
//   i_clk, i_reset   : clock and synchronous active-high reset
//   i_vsync, i_href  : camera frame and line framing
//   i_byte_valid     : one-cycle strobe per camera byte
//   i_data           : camera byte
//   i_start          : pulse that requests one capture
//   i_continuous     : level; re-arm after each done
//   i_done           : pulse from the colour stage; frame consumed
//   o_ram_*          : frame RAM write port
//   o_frame_ready    : frame valid in RAM
//   o_busy           : waiting for a frame or capturing one
//   o_short_frame    : sticky; a frame had too few bytes
//   o_overflow       : sticky; a frame had too many bytes
module camera_frame_capture #(
  parameter int BYTES_PER_FRAME = 19200,
  parameter int ADDR_W          = 15
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_vsync,
  input  logic              i_href,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_data,
  input  logic              i_start,
  input  logic              i_continuous,
  input  logic              i_done,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [7:0]        o_ram_data,
  output logic              o_frame_ready,
  output logic              o_busy,
  output logic              o_short_frame,
  output logic              o_overflow
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VSYNC,
    CAPTURE,
    READY
  } state_e;

  // One extra count bit so a full frame never wraps to zero.
  localparam logic [ADDR_W:0] FRAME_LEN =
    (ADDR_W+1)'(BYTES_PER_FRAME);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              vsync_q;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              short_q, short_d;
  logic              ovf_q, ovf_d;

  logic vs_fall;
  logic vs_rise;
  logic accept;

  assign vs_fall = vsync_q & ~i_vsync;
  assign vs_rise = ~vsync_q & i_vsync;
  // End of frame wins over a byte strobed in the same cycle.
  assign accept  = i_href & i_byte_valid & ~vs_rise;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    short_d = short_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (i_start | i_continuous) begin
          state_d = WAIT_VSYNC;
          count_d = '0;
          short_d = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      WAIT_VSYNC: begin
        // Arming mid-frame must wait for a fresh frame start.
        if (vs_fall) begin
          state_d = CAPTURE;
          count_d = '0;
        end
      end
      CAPTURE: begin
        if (vs_rise) begin
          if (count_q == FRAME_LEN) begin
            state_d = READY;
          end else begin
            short_d = 1'b1;
            state_d = WAIT_VSYNC;
          end
        end else if (accept) begin
          if (count_q < FRAME_LEN) begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_W-1:0];
            data_d  = i_data;
            count_d = count_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      READY: begin
        if (i_done) begin
          if (i_continuous) begin
            state_d = WAIT_VSYNC;
            count_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      count_q <= '0;
      vsync_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      short_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      vsync_q <= i_vsync;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      short_q <= short_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_ram_we      = we_q;
  assign o_ram_addr    = addr_q;
  assign o_ram_data    = data_q;
  assign o_frame_ready = (state_q == READY);
  assign o_busy        = (state_q == WAIT_VSYNC) |
                         (state_q == CAPTURE);
  assign o_short_frame = short_q;
  assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_camera_frame_capture.sv
// Directed bench for camera_frame_capture with an 8-byte frame.
// Expected values are hand-computed; RAM writes are collected into a local array.
module tb_camera_frame_capture;

  localparam int BPF = 8;
  localparam int AW  = 15;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_vsync;
  logic          i_href;
  logic          i_byte_valid;
  logic [7:0]    i_data;
  logic          i_start;
  logic          i_continuous;
  logic          i_done;
  logic          o_ram_we;
  logic [AW-1:0] o_ram_addr;
  logic [7:0]    o_ram_data;
  logic          o_frame_ready;
  logic          o_busy;
  logic          o_short_frame;
  logic          o_overflow;

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;
  int bad_addr = 0;
  logic [7:0] mem [0:BPF-1];

  camera_frame_capture #(
    .BYTES_PER_FRAME(BPF),
    .ADDR_W(AW)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_vsync(i_vsync),
    .i_href(i_href),
    .i_byte_valid(i_byte_valid),
    .i_data(i_data),
    .i_start(i_start),
    .i_continuous(i_continuous),
    .i_done(i_done),
    .o_ram_we(o_ram_we),
    .o_ram_addr(o_ram_addr),
    .o_ram_data(o_ram_data),
    .o_frame_ready(o_frame_ready),
    .o_busy(o_busy),
    .o_short_frame(o_short_frame),
    .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_ram_we) begin
      n_writes++;
      if (o_ram_addr < AW'(BPF)) mem[o_ram_addr[2:0]] = o_ram_data;
      else bad_addr++;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d,
                      input logic       exp_we,
                      input int         exp_addr);
    i_href       = 1'b1;
    i_byte_valid = 1'b1;
    i_data       = d;
    cyc();
    check("we", 32'(o_ram_we), 32'(exp_we));
    if (exp_we) begin
      check("addr", 32'(o_ram_addr), 32'(exp_addr));
      check("data", 32'(o_ram_data), 32'(d));
    end
    i_href       = 1'b0;
    i_byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
  endtask

  task automatic pulse_done();
    i_done = 1'b1;
    cyc();
    i_done = 1'b0;
  endtask

  task automatic frame_start();
    i_vsync = 1'b0;
    cyc();
  endtask

  task automatic frame_end();
    i_vsync = 1'b1;
    cyc();
  endtask

  int base;

  initial begin
    i_reset      = 1'b1;
    i_vsync      = 1'b1;
    i_href       = 1'b0;
    i_byte_valid = 1'b0;
    i_data       = 8'h00;
    i_start      = 1'b0;
    i_continuous = 1'b0;
    i_done       = 1'b0;
    cyc();
    cyc();
    i_reset = 1'b0;
    cyc();
    check("rst_we", 32'(o_ram_we), 0);
    check("rst_addr", 32'(o_ram_addr), 0);
    check("rst_data", 32'(o_ram_data), 0);
    check("rst_rdy", 32'(o_frame_ready), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_short", 32'(o_short_frame), 0);
    check("rst_ovf", 32'(o_overflow), 0);

    // Nominal frame: two lines of four bytes
    pulse_start();
    check("nom_busy", 32'(o_busy), 1);
    frame_start();
    for (int i = 0; i < 4; i++) send(8'(8'h11 * (i + 1)), 1'b1, i);
    cyc();
    check("nom_gap_we", 32'(o_ram_we), 0);
    for (int i = 4; i < 8; i++) send(8'(8'h11 * (i + 1)), 1'b1, i);
    frame_end();
    check("nom_rdy", 32'(o_frame_ready), 1);
    check("nom_busy2", 32'(o_busy), 0);
    check("nom_short", 32'(o_short_frame), 0);
    check("nom_nwr", 32'(n_writes), 8);
    check("nom_m0", 32'(mem[0]), 32'h11);
    check("nom_m7", 32'(mem[7]), 32'h88);
    cyc();
    check("nom_rdy_hold", 32'(o_frame_ready), 1);
    pulse_done();
    check("nom_rdy_drop", 32'(o_frame_ready), 0);
    check("nom_idle", 32'(o_busy), 0);

    // Arm in the middle of a frame
    frame_start();
    pulse_start();
    base = n_writes;
    for (int i = 0; i < 3; i++) send(8'h5A, 1'b0, 0);
    frame_end();
    check("mid_nwr", 32'(n_writes - base), 0);
    frame_start();
    for (int i = 0; i < 8; i++) send(8'(8'h21 + i), 1'b1, i);
    frame_end();
    check("mid_rdy", 32'(o_frame_ready), 1);
    check("mid_nwr2", 32'(n_writes - base), 8);
    check("mid_m0", 32'(mem[0]), 32'h21);
    pulse_done();

    // Short frame then a full one
    pulse_start();
    frame_start();
    for (int i = 0; i < 6; i++) send(8'(8'h31 + i), 1'b1, i);
    frame_end();
    check("sh_flag", 32'(o_short_frame), 1);
    check("sh_rdy", 32'(o_frame_ready), 0);
    check("sh_busy", 32'(o_busy), 1);
    frame_start();
    for (int i = 0; i < 8; i++) send(8'(8'h41 + i), 1'b1, i);
    frame_end();
    check("sh_rdy2", 32'(o_frame_ready), 1);
    check("sh_flag2", 32'(o_short_frame), 1);
    pulse_done();

    // Overflow: ten bytes, plus a byte on the vsync rise
    pulse_start();
    check("ov_clr_short", 32'(o_short_frame), 0);
    frame_start();
    base = n_writes;
    for (int i = 0; i < 8; i++) send(8'(8'h51 + i), 1'b1, i);
    send(8'hE1, 1'b0, 0);
    check("ov_flag", 32'(o_overflow), 1);
    send(8'hE2, 1'b0, 0);
    i_vsync      = 1'b1;
    i_href       = 1'b1;
    i_byte_valid = 1'b1;
    i_data       = 8'hEE;
    cyc();
    i_href       = 1'b0;
    i_byte_valid = 1'b0;
    check("ov_rise_we", 32'(o_ram_we), 0);
    check("ov_rdy", 32'(o_frame_ready), 1);
    check("ov_flag2", 32'(o_overflow), 1);
    check("ov_nwr", 32'(n_writes - base), 8);
    check("ov_m7", 32'(mem[7]), 32'h58);
    pulse_done();

    // Continuous capture of two frames
    i_continuous = 1'b1;
    cyc();
    check("ct_busy", 32'(o_busy), 1);
    check("ct_clr_ovf", 32'(o_overflow), 0);
    frame_start();
    for (int i = 0; i < 8; i++) send(8'(8'hA0 + i), 1'b1, i);
    frame_end();
    check("ct_rdy", 32'(o_frame_ready), 1);
    base = n_writes;
    frame_start();
    for (int i = 0; i < 8; i++) send(8'(8'hB0 + i), 1'b0, 0);
    frame_end();
    check("ct_hold_nwr", 32'(n_writes - base), 0);
    check("ct_hold_m0", 32'(mem[0]), 32'hA0);
    pulse_done();
    check("ct_rearm", 32'(o_busy), 1);
    check("ct_rdy_drop", 32'(o_frame_ready), 0);
    frame_start();
    for (int i = 0; i < 8; i++) send(8'(8'hB0 + i), 1'b1, i);
    frame_end();
    check("ct_rdy2", 32'(o_frame_ready), 1);
    check("ct_m0", 32'(mem[0]), 32'hB0);
    check("ct_m7", 32'(mem[7]), 32'hB7);
    i_continuous = 1'b0;
    pulse_done();
    check("ct_idle", 32'(o_busy), 0);

    // Reset in the middle of a capture
    pulse_start();
    frame_start();
    for (int i = 0; i < 4; i++) send(8'(8'hC0 + i), 1'b1, i);
    i_reset      = 1'b1;
    i_href       = 1'b1;
    i_byte_valid = 1'b1;
    i_data       = 8'hC4;
    cyc();
    i_href       = 1'b0;
    i_byte_valid = 1'b0;
    i_reset      = 1'b0;
    check("rm_we", 32'(o_ram_we), 0);
    check("rm_addr", 32'(o_ram_addr), 0);
    check("rm_busy", 32'(o_busy), 0);
    check("rm_rdy", 32'(o_frame_ready), 0);
    base = n_writes;
    pulse_done();
    check("rm_done_rdy", 32'(o_frame_ready), 0);
    check("rm_done_busy", 32'(o_busy), 0);
    cyc();
    check("rm_nwr", 32'(n_writes - base), 0);
    check("bad_addr", 32'(bad_addr), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
